// File: rtl/data_path_pipe_if.sv
// -----------------------------------------------------------------------------
// data_path_pipe_if
// Bundles every signal between the operand/flag datapath and its surroundings
// (register file, ALU, sequencer). Clock and reset are kept outside.
//   master : the controlling side (sequencer / register file / ALU models)
//   slave  : the datapath itself
// Signals:
//   Reset_AluRegs           synchronous clear of the operand stage
//   Crnt_Instrn             current instruction word
//   in_valid / in_ready     operand load handshake
//   Use_Imm_B, Use_Imm_WB   operand B / writeback source selects
//   Fwd_En                  result forwarding enable
//   RegPort_A/B             register-file read data
//   Addr_A/B/C              register-file addresses
//   Oprnd_A/B               staged operands
//   opr_valid / opr_ready   staged operand handshake towards the ALU
//   Op_Result, res_valid, res_addr  ALU result and destination
//   RegPort_C               writeback data
//   ALU_*                   live ALU flags
//   Latch_Flags, Flag_Mask  PSW latch control, mask order {Ovf,Carry,Neg,Zro}
//   Psw_Save, Psw_Restore   shadow PSW control
//   *_Flag                  selected flag outputs
// -----------------------------------------------------------------------------
interface data_path_pipe_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7
);
   logic              Reset_AluRegs;
   logic [31:0]       Crnt_Instrn;
   logic              in_valid;
   logic              in_ready;
   logic              Use_Imm_B;
   logic              Use_Imm_WB;
   logic              Fwd_En;
   logic [DATA_W-1:0] RegPort_A;
   logic [DATA_W-1:0] RegPort_B;
   logic [ADDR_W-1:0] Addr_A;
   logic [ADDR_W-1:0] Addr_B;
   logic [ADDR_W-1:0] Addr_C;
   logic [DATA_W-1:0] Oprnd_A;
   logic [DATA_W-1:0] Oprnd_B;
   logic              opr_valid;
   logic              opr_ready;
   logic [DATA_W-1:0] Op_Result;
   logic              res_valid;
   logic [ADDR_W-1:0] res_addr;
   logic [DATA_W-1:0] RegPort_C;
   logic              ALU_Zro;
   logic              ALU_Neg;
   logic              ALU_Carry;
   logic              ALU_Ovf;
   logic              Latch_Flags;
   logic [3:0]        Flag_Mask;
   logic              Psw_Save;
   logic              Psw_Restore;
   logic              Zro_Flag;
   logic              Neg_Flag;
   logic              Carry_Flag;
   logic              Ovf_Flag;

   modport master (
      output Reset_AluRegs, Crnt_Instrn, in_valid, Use_Imm_B, Use_Imm_WB, Fwd_En,
             RegPort_A, RegPort_B, opr_ready, Op_Result, res_valid, res_addr,
             ALU_Zro, ALU_Neg, ALU_Carry, ALU_Ovf, Latch_Flags, Flag_Mask,
             Psw_Save, Psw_Restore,
      input  in_ready, Addr_A, Addr_B, Addr_C, Oprnd_A, Oprnd_B, opr_valid,
             RegPort_C, Zro_Flag, Neg_Flag, Carry_Flag, Ovf_Flag
   );

   modport slave (
      input  Reset_AluRegs, Crnt_Instrn, in_valid, Use_Imm_B, Use_Imm_WB, Fwd_En,
             RegPort_A, RegPort_B, opr_ready, Op_Result, res_valid, res_addr,
             ALU_Zro, ALU_Neg, ALU_Carry, ALU_Ovf, Latch_Flags, Flag_Mask,
             Psw_Save, Psw_Restore,
      output in_ready, Addr_A, Addr_B, Addr_C, Oprnd_A, Oprnd_B, opr_valid,
             RegPort_C, Zro_Flag, Neg_Flag, Carry_Flag, Ovf_Flag
   );
endinterface

// File: rtl/data_path_pipe.sv
// -----------------------------------------------------------------------------
// data_path_pipe
// Operand/flag datapath between the register file and the ALU.
//   - One valid/ready operand register with single-entry result forwarding.
//   - 4-flag PSW latched under a per-flag mask, plus a one-deep shadow PSW.
//   - Combinational register address, writeback and flag source selection.
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous active-high reset
//   bus    data_path_pipe_if.slave, all datapath signals
// -----------------------------------------------------------------------------
module data_path_pipe #(
   parameter int          DATA_W       = 16,
   parameter int          IMM_W        = 8,
   parameter int          ADDR_W       = 7,
   parameter bit          SIGN_EXT_IMM = 1'b0,
   parameter logic [7:0]  PSW_RD_OP    = 8'h08
) (
   input  logic               clk,
   input  logic               reset,
   data_path_pipe_if.slave    bus
);

   logic [DATA_W-1:0] oprnd_a_q, oprnd_a_d;
   logic [DATA_W-1:0] oprnd_b_q, oprnd_b_d;
   logic              opr_valid_q, opr_valid_d;
   // PSW bit order {Ovf,Carry,Neg,Zro}, matching Flag_Mask
   logic [3:0]        psw_q, psw_d;
   logic [3:0]        shadow_q, shadow_d;

   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] wb_imm;
   logic [ADDR_W-1:0] addr_a;
   logic              load;
   logic              fwd_a, fwd_b;
   logic [3:0]        alu_flags;

   // ---------------- immediate extension ----------------
   generate
      if (IMM_W == DATA_W) begin : g_imm_full
         assign imm_ext = bus.Crnt_Instrn[IMM_W-1:0];
      end else if (SIGN_EXT_IMM) begin : g_imm_sext
         assign imm_ext = {{(DATA_W-IMM_W){bus.Crnt_Instrn[IMM_W-1]}},
                           bus.Crnt_Instrn[IMM_W-1:0]};
      end else begin : g_imm_zext
         assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, bus.Crnt_Instrn[IMM_W-1:0]};
      end
   endgenerate

   // Writeback immediate is at most the low 16 instruction bits
   generate
      if (DATA_W > 16) begin : g_wb_wide
         assign wb_imm = {{(DATA_W-16){1'b0}}, bus.Crnt_Instrn[15:0]};
      end else begin : g_wb_narrow
         assign wb_imm = bus.Crnt_Instrn[DATA_W-1:0];
      end
   endgenerate

   // ---------------- addresses / writeback ----------------
   // Class-00 instructions with bit 24 set read A from the low field
   assign addr_a = ((bus.Crnt_Instrn[31:30] == 2'b00) && bus.Crnt_Instrn[24])
                   ? bus.Crnt_Instrn[ADDR_W-1:0]
                   : bus.Crnt_Instrn[8 +: ADDR_W];
   assign bus.Addr_A    = addr_a;
   assign bus.Addr_B    = bus.Crnt_Instrn[ADDR_W-1:0];
   assign bus.Addr_C    = bus.Crnt_Instrn[16 +: ADDR_W];
   assign bus.RegPort_C = bus.Use_Imm_WB ? wb_imm : bus.Op_Result;

   // ---------------- operand stage ----------------
   assign bus.in_ready = !opr_valid_q || bus.opr_ready;
   assign load         = bus.in_valid && bus.in_ready;
   assign fwd_a = bus.Fwd_En && bus.res_valid && (bus.res_addr == addr_a);
   assign fwd_b = bus.Fwd_En && bus.res_valid && (bus.res_addr == bus.Crnt_Instrn[ADDR_W-1:0]);

   always_comb begin
      oprnd_a_d   = oprnd_a_q;
      oprnd_b_d   = oprnd_b_q;
      opr_valid_d = opr_valid_q;
      if (bus.Reset_AluRegs) begin
         oprnd_a_d   = '0;
         oprnd_b_d   = '0;
         opr_valid_d = 1'b0;
      end else if (load) begin
         opr_valid_d = 1'b1;
         oprnd_a_d   = fwd_a ? bus.Op_Result : bus.RegPort_A;
         if (bus.Use_Imm_B)
            oprnd_b_d = imm_ext;
         else
            oprnd_b_d = fwd_b ? bus.Op_Result : bus.RegPort_B;
      end else if (bus.opr_ready) begin
         opr_valid_d = 1'b0;
      end
   end

   // ---------------- PSW / shadow ----------------
   assign alu_flags = {bus.ALU_Ovf, bus.ALU_Carry, bus.ALU_Neg, bus.ALU_Zro};

   always_comb begin
      psw_d    = psw_q;
      shadow_d = shadow_q;
      if (bus.Psw_Restore && bus.Psw_Save) begin
         psw_d    = shadow_q;
         shadow_d = psw_q;
      end else if (bus.Psw_Restore) begin
         psw_d = shadow_q;
      end else begin
         // Save captures the pre-edge PSW while a latch still updates it
         if (bus.Psw_Save)
            shadow_d = psw_q;
         if (bus.Latch_Flags)
            psw_d = (bus.Flag_Mask & alu_flags) | (~bus.Flag_Mask & psw_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oprnd_a_q   <= '0;
         oprnd_b_q   <= '0;
         opr_valid_q <= 1'b0;
         psw_q       <= '0;
         shadow_q    <= '0;
      end else begin
         oprnd_a_q   <= oprnd_a_d;
         oprnd_b_q   <= oprnd_b_d;
         opr_valid_q <= opr_valid_d;
         psw_q       <= psw_d;
         shadow_q    <= shadow_d;
      end
   end

   assign bus.Oprnd_A   = oprnd_a_q;
   assign bus.Oprnd_B   = oprnd_b_q;
   assign bus.opr_valid = opr_valid_q;

   // ---------------- flag output select ----------------
   assign {bus.Ovf_Flag, bus.Carry_Flag, bus.Neg_Flag, bus.Zro_Flag} =
      (bus.Crnt_Instrn[31:24] == PSW_RD_OP) ? psw_q : alu_flags;

endmodule

// File: tb/tb_data_path_pipe.sv
// -----------------------------------------------------------------------------
// tb_data_path_pipe
// Directed bench for data_path_pipe. A second instance with sign-extended
// immediates shares all inputs with the first.
// -----------------------------------------------------------------------------
module tb_data_path_pipe;

   logic clk;
   logic reset;
   int   pass_cnt;
   int   total_cnt;

   data_path_pipe_if #(.DATA_W(16), .ADDR_W(7)) bus0 ();
   data_path_pipe_if #(.DATA_W(16), .ADDR_W(7)) bus1 ();

   data_path_pipe #(.SIGN_EXT_IMM(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
   data_path_pipe #(.SIGN_EXT_IMM(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   assign bus1.Reset_AluRegs = bus0.Reset_AluRegs;
   assign bus1.Crnt_Instrn   = bus0.Crnt_Instrn;
   assign bus1.in_valid      = bus0.in_valid;
   assign bus1.Use_Imm_B     = bus0.Use_Imm_B;
   assign bus1.Use_Imm_WB    = bus0.Use_Imm_WB;
   assign bus1.Fwd_En        = bus0.Fwd_En;
   assign bus1.RegPort_A     = bus0.RegPort_A;
   assign bus1.RegPort_B     = bus0.RegPort_B;
   assign bus1.opr_ready     = bus0.opr_ready;
   assign bus1.Op_Result     = bus0.Op_Result;
   assign bus1.res_valid     = bus0.res_valid;
   assign bus1.res_addr      = bus0.res_addr;
   assign bus1.ALU_Zro       = bus0.ALU_Zro;
   assign bus1.ALU_Neg       = bus0.ALU_Neg;
   assign bus1.ALU_Carry     = bus0.ALU_Carry;
   assign bus1.ALU_Ovf       = bus0.ALU_Ovf;
   assign bus1.Latch_Flags   = bus0.Latch_Flags;
   assign bus1.Flag_Mask     = bus0.Flag_Mask;
   assign bus1.Psw_Save      = bus0.Psw_Save;
   assign bus1.Psw_Restore   = bus0.Psw_Restore;

   logic [3:0] flags;
   assign flags = {bus0.Ovf_Flag, bus0.Carry_Flag, bus0.Neg_Flag, bus0.Zro_Flag};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic [3:0] f);
      {bus0.ALU_Ovf, bus0.ALU_Carry, bus0.ALU_Neg, bus0.ALU_Zro} = f;
   endtask

   task automatic test_reset();
      total_cnt++;
      if (bus0.opr_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", bus0.opr_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus0.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b exp=1", bus0.in_ready);
      else pass_cnt++;
      // stall an entry and latch all flags
      bus0.in_valid = 1; bus0.opr_ready = 0;
      bus0.RegPort_A = 16'hAAAA; bus0.RegPort_B = 16'h5555;
      bus0.Crnt_Instrn = 32'h0800_0000;
      set_alu(4'b1111); bus0.Latch_Flags = 1; bus0.Flag_Mask = 4'b1111;
      tick();
      bus0.in_valid = 0; bus0.Latch_Flags = 0; set_alu(4'b0000);
      total_cnt++;
      if (bus0.opr_valid !== 1'b1 || bus0.Oprnd_A !== 16'hAAAA || flags !== 4'b1111)
         $display("FAIL stall_pre_reset valid=%0b A=%h flags=%b exp valid=1 A=aaaa flags=1111",
                  bus0.opr_valid, bus0.Oprnd_A, flags);
      else pass_cnt++;
      #2 reset = 1;
      #1;
      total_cnt++;
      if (bus0.opr_valid !== 1'b0 || bus0.Oprnd_A !== 16'h0 || bus0.Oprnd_B !== 16'h0)
         $display("FAIL async_reset_opr valid=%0b A=%h B=%h exp 0/0000/0000",
                  bus0.opr_valid, bus0.Oprnd_A, bus0.Oprnd_B);
      else pass_cnt++;
      total_cnt++;
      if (flags !== 4'b0000 || bus0.in_ready !== 1'b1)
         $display("FAIL async_reset_psw flags=%b in_ready=%0b exp 0000/1", flags, bus0.in_ready);
      else pass_cnt++;
      @(negedge clk);
      reset = 0;
      $display("test_reset done");
   endtask

   task automatic test_back_to_back();
      bus0.Crnt_Instrn = 32'h0; bus0.opr_ready = 1; bus0.in_valid = 1;
      bus0.RegPort_A = 16'h1234;
      tick();
      total_cnt++;
      if (bus0.Oprnd_A !== 16'h1234 || bus0.opr_valid !== 1'b1)
         $display("FAIL b2b_first A=%h valid=%0b exp 1234/1", bus0.Oprnd_A, bus0.opr_valid);
      else pass_cnt++;
      bus0.RegPort_A = 16'h5678;
      tick();
      total_cnt++;
      if (bus0.Oprnd_A !== 16'h5678 || bus0.opr_valid !== 1'b1)
         $display("FAIL b2b_second A=%h valid=%0b exp 5678/1", bus0.Oprnd_A, bus0.opr_valid);
      else pass_cnt++;
      bus0.in_valid = 0;
      tick();
      total_cnt++;
      if (bus0.opr_valid !== 1'b0)
         $display("FAIL b2b_drain valid=%0b exp 0", bus0.opr_valid);
      else pass_cnt++;
      $display("test_back_to_back done");
   endtask

   task automatic test_stall_clear();
      bus0.opr_ready = 0; bus0.in_valid = 1; bus0.RegPort_A = 16'h1111;
      tick();
      bus0.RegPort_A = 16'h2222;
      total_cnt++;
      if (bus0.in_ready !== 1'b0)
         $display("FAIL stall_in_ready got=%0b exp 0", bus0.in_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus0.Oprnd_A !== 16'h1111 || bus0.opr_valid !== 1'b1)
         $display("FAIL stall_hold A=%h valid=%0b exp 1111/1", bus0.Oprnd_A, bus0.opr_valid);
      else pass_cnt++;
      // clear with a load that would otherwise be accepted
      bus0.opr_ready = 1; bus0.RegPort_A = 16'h3333; bus0.Reset_AluRegs = 1;
      tick();
      bus0.Reset_AluRegs = 0; bus0.in_valid = 0;
      total_cnt++;
      if (bus0.Oprnd_A !== 16'h0 || bus0.opr_valid !== 1'b0)
         $display("FAIL alu_regs_clear A=%h valid=%0b exp 0000/0", bus0.Oprnd_A, bus0.opr_valid);
      else pass_cnt++;
      $display("test_stall_clear done");
   endtask

   task automatic test_forwarding();
      bus0.Crnt_Instrn = 32'h0000_0505; bus0.Use_Imm_B = 0;
      bus0.res_valid = 1; bus0.res_addr = 7'h05; bus0.Op_Result = 16'hBEEF;
      bus0.RegPort_A = 16'h1357; bus0.RegPort_B = 16'h2468;
      bus0.Fwd_En = 1; bus0.in_valid = 1; bus0.opr_ready = 1;
      tick();
      total_cnt++;
      if (bus0.Oprnd_A !== 16'hBEEF || bus0.Oprnd_B !== 16'hBEEF)
         $display("FAIL fwd_on A=%h B=%h exp beef/beef", bus0.Oprnd_A, bus0.Oprnd_B);
      else pass_cnt++;
      bus0.Fwd_En = 0;
      tick();
      total_cnt++;
      if (bus0.Oprnd_A !== 16'h1357 || bus0.Oprnd_B !== 16'h2468)
         $display("FAIL fwd_off A=%h B=%h exp 1357/2468", bus0.Oprnd_A, bus0.Oprnd_B);
      else pass_cnt++;
      // address mismatch: forward enabled but no hit
      bus0.Fwd_En = 1; bus0.res_addr = 7'h06;
      tick();
      bus0.res_valid = 0; bus0.Fwd_En = 0; bus0.in_valid = 0;
      total_cnt++;
      if (bus0.Oprnd_A !== 16'h1357 || bus0.Oprnd_B !== 16'h2468)
         $display("FAIL fwd_miss A=%h B=%h exp 1357/2468", bus0.Oprnd_A, bus0.Oprnd_B);
      else pass_cnt++;
      $display("test_forwarding done");
   endtask

   task automatic test_addr_wb();
      bus0.Crnt_Instrn = 32'h0112_3403;
      #1;
      total_cnt++;
      if (bus0.Addr_A !== 7'h03 || bus0.Addr_B !== 7'h03 || bus0.Addr_C !== 7'h12)
         $display("FAIL addr_low A=%h B=%h C=%h exp 03/03/12", bus0.Addr_A, bus0.Addr_B, bus0.Addr_C);
      else pass_cnt++;
      bus0.Crnt_Instrn = 32'h4112_3403;
      #1;
      total_cnt++;
      if (bus0.Addr_A !== 7'h34)
         $display("FAIL addr_high A=%h exp 34", bus0.Addr_A);
      else pass_cnt++;
      bus0.Use_Imm_WB = 1; bus0.Op_Result = 16'hBEEF;
      #1;
      total_cnt++;
      if (bus0.RegPort_C !== 16'h3403)
         $display("FAIL wb_imm got=%h exp 3403", bus0.RegPort_C);
      else pass_cnt++;
      bus0.Use_Imm_WB = 0;
      #1;
      total_cnt++;
      if (bus0.RegPort_C !== 16'hBEEF)
         $display("FAIL wb_result got=%h exp beef", bus0.RegPort_C);
      else pass_cnt++;
      $display("test_addr_wb done");
   endtask

   task automatic test_imm();
      @(negedge clk);
      bus0.Crnt_Instrn = 32'h0000_0080; bus0.Use_Imm_B = 1;
      bus0.in_valid = 1; bus0.opr_ready = 1;
      tick();
      total_cnt++;
      if (bus0.Oprnd_B !== 16'h0080 || bus1.Oprnd_B !== 16'hFF80)
         $display("FAIL imm_80 zext=%h sext=%h exp 0080/ff80", bus0.Oprnd_B, bus1.Oprnd_B);
      else pass_cnt++;
      bus0.Crnt_Instrn = 32'h0000_007F;
      tick();
      bus0.in_valid = 0; bus0.Use_Imm_B = 0;
      total_cnt++;
      if (bus0.Oprnd_B !== 16'h007F || bus1.Oprnd_B !== 16'h007F)
         $display("FAIL imm_7f zext=%h sext=%h exp 007f/007f", bus0.Oprnd_B, bus1.Oprnd_B);
      else pass_cnt++;
      $display("test_imm done");
   endtask

   task automatic test_psw();
      bus0.Crnt_Instrn = 32'h0800_0000;
      set_alu(4'b1111); bus0.Latch_Flags = 1; bus0.Flag_Mask = 4'b0101;
      tick();
      set_alu(4'b1010); bus0.Latch_Flags = 0;
      total_cnt++;
      if (flags !== 4'b0101) $display("FAIL psw_mask_latch got=%b exp 0101", flags);
      else pass_cnt++;
      bus0.Psw_Save = 1;
      tick();
      bus0.Psw_Save = 0;
      set_alu(4'b0000); bus0.Latch_Flags = 1; bus0.Flag_Mask = 4'b1111;
      tick();
      total_cnt++;
      if (flags !== 4'b0000) $display("FAIL psw_latch_zero got=%b exp 0000", flags);
      else pass_cnt++;
      set_alu(4'b1111); bus0.Psw_Restore = 1;
      tick();
      bus0.Psw_Restore = 0; bus0.Latch_Flags = 0;
      total_cnt++;
      if (flags !== 4'b0101) $display("FAIL psw_restore got=%b exp 0101", flags);
      else pass_cnt++;
      bus0.Crnt_Instrn = 32'h0000_0000; set_alu(4'b1010);
      #1;
      total_cnt++;
      if (flags !== 4'b1010) $display("FAIL live_flags got=%b exp 1010", flags);
      else pass_cnt++;
      // swap: PSW=0011, shadow=0101
      bus0.Crnt_Instrn = 32'h0800_0000;
      set_alu(4'b0011); bus0.Latch_Flags = 1;
      tick();
      bus0.Latch_Flags = 0; bus0.Psw_Save = 1; bus0.Psw_Restore = 1;
      tick();
      bus0.Psw_Save = 0;
      total_cnt++;
      if (flags !== 4'b0101) $display("FAIL psw_swap got=%b exp 0101", flags);
      else pass_cnt++;
      tick();
      bus0.Psw_Restore = 0;
      total_cnt++;
      if (flags !== 4'b0011) $display("FAIL psw_swap_shadow got=%b exp 0011", flags);
      else pass_cnt++;
      // save and latch together: shadow gets 0011, PSW gets 1000
      set_alu(4'b1000); bus0.Latch_Flags = 1; bus0.Psw_Save = 1;
      tick();
      bus0.Latch_Flags = 0; bus0.Psw_Save = 0;
      total_cnt++;
      if (flags !== 4'b1000) $display("FAIL psw_save_latch got=%b exp 1000", flags);
      else pass_cnt++;
      bus0.Reset_AluRegs = 1;
      tick();
      bus0.Reset_AluRegs = 0;
      total_cnt++;
      if (flags !== 4'b1000) $display("FAIL psw_alu_regs_keep got=%b exp 1000", flags);
      else pass_cnt++;
      bus0.Psw_Restore = 1;
      tick();
      bus0.Psw_Restore = 0;
      total_cnt++;
      if (flags !== 4'b0011) $display("FAIL psw_save_old got=%b exp 0011", flags);
      else pass_cnt++;
      $display("test_psw done");
   endtask

   initial begin
      pass_cnt = 0; total_cnt = 0;
      reset = 1;
      bus0.Reset_AluRegs = 0; bus0.Crnt_Instrn = 32'h0; bus0.in_valid = 0;
      bus0.Use_Imm_B = 0; bus0.Use_Imm_WB = 0; bus0.Fwd_En = 0;
      bus0.RegPort_A = '0; bus0.RegPort_B = '0; bus0.opr_ready = 0;
      bus0.Op_Result = '0; bus0.res_valid = 0; bus0.res_addr = '0;
      set_alu(4'b0000); bus0.Latch_Flags = 0; bus0.Flag_Mask = 4'b0000;
      bus0.Psw_Save = 0; bus0.Psw_Restore = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      test_reset();
      test_back_to_back();
      test_stall_clear();
      test_forwarding();
      test_addr_wb();
      test_imm();
      test_psw();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
